// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides the system clock into a pixel enable and
// produces registered sync/active plus raw pixel coordinates and start strobes.
module vga_sync_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_params
            $error("vga_sync_gen: illegal timing parameters");
        end
    endgenerate

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] HA       = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VA       = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0]  div_cnt;
    logic        run;
    logic [9:0]  h_cnt, v_cnt;
    logic [9:0]  h_nxt, v_nxt;
    logic [10:0] h_ext, v_ext;

    always_comb begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
    end

    assign h_ext = {1'b0, h_nxt};
    assign v_ext = {1'b0, v_nxt};

    // Sync/active follow the next-state counters so they line up with x/y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            run     <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync   <= ~HS_POL;
            vsync   <= ~VS_POL;
            active  <= 1'b1;
        end else begin
            run     <= 1'b1;
            div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
            if (pix_en) begin
                h_cnt  <= h_nxt;
                v_cnt  <= v_nxt;
                active <= (h_ext < HA) && (v_ext < VA);
                hsync  <= (h_ext >= HS_BEG && h_ext < HS_END) ? HS_POL : ~HS_POL;
                vsync  <= (v_ext >= VS_BEG && v_ext < VS_END) ? VS_POL : ~VS_POL;
            end
        end
    end

    assign pix_en      = run && (div_cnt == DIV_LAST);
    assign line_start  = pix_en && (h_cnt == 10'd0);
    assign frame_start = line_start && (v_cnt == 10'd0);
    assign x           = h_cnt;
    assign y           = v_cnt;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance, a shrunken CLK_DIV=1 positive-polarity
// instance for frame-level behaviour, and a CLK_DIV=3 instance for divider start-up.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic       pe0, hs0, vs0, act0, ls0, fs0;
    logic [9:0] x0, y0;
    logic       pe1, hs1, vs1, act1, ls1, fs1;
    logic [9:0] x1, y1;
    logic       pe2, hs2, vs2, act2, ls2, fs2;
    logic [9:0] x2, y2;

    vga_sync_gen dut0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe0), .hsync(hs0), .vsync(vs0), .active(act0),
        .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
    );

    // 15 pixels x 8 lines, hsync at x=10..12, vsync at y=5..6, both active-high.
    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe1), .hsync(hs1), .vsync(vs1), .active(act1),
        .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
    );

    vga_sync_gen #(.CLK_DIV(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe2), .hsync(hs2), .vsync(vs2), .active(act2),
        .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         n;
        logic [9:0] x, y;
        logic       hs, vs, act, pe, ls, fs;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl[NV];

    initial begin
        int idx, n, waited;
        int pe_cnt0, hs_low0, ls_cnt0, alt_bad, xadv_bad;
        int pe_cnt1, hs_hi1, vs_hi1, fs_cnt1, pe_cnt2;
        logic [9:0] prev_x;
        logic prev_pe;

        // n = negedge index after the first edge with rst_n=1 (dut0, CLK_DIV=2)
        tbl[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1278, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1279, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1310, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1311, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1502, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1503, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1598, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1599, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1600, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1601, 10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst0_x", 32'(x0), 0);
        chk("rst0_y", 32'(y0), 0);
        chk("rst0_act", 32'(act0), 1);
        chk("rst0_hs", 32'(hs0), 1);
        chk("rst0_vs", 32'(vs0), 1);
        chk("rst0_pe", 32'(pe0), 0);
        chk("rst0_strobes", 32'({ls0, fs0}), 0);
        chk("rst1_syncs", 32'({hs1, vs1}), 0);
        chk("rst1_pe", 32'(pe1), 0);

        rst_n = 1'b1;
        idx = 0;
        pe_cnt0 = 0; hs_low0 = 0; ls_cnt0 = 0; alt_bad = 0; xadv_bad = 0;
        pe_cnt1 = 0; hs_hi1 = 0; vs_hi1 = 0; fs_cnt1 = 0; pe_cnt2 = 0;
        prev_x = '0; prev_pe = 1'b0;
        for (n = 0; n <= 1601; n++) begin
            @(negedge clk);
            if (idx < NV && tbl[idx].n == n) begin
                chk($sformatf("v%0d_x", idx), 32'(x0), 32'(tbl[idx].x));
                chk($sformatf("v%0d_y", idx), 32'(y0), 32'(tbl[idx].y));
                chk($sformatf("v%0d_hs", idx), 32'(hs0), 32'(tbl[idx].hs));
                chk($sformatf("v%0d_vs", idx), 32'(vs0), 32'(tbl[idx].vs));
                chk($sformatf("v%0d_act", idx), 32'(act0), 32'(tbl[idx].act));
                chk($sformatf("v%0d_pe", idx), 32'(pe0), 32'(tbl[idx].pe));
                chk($sformatf("v%0d_ls", idx), 32'(ls0), 32'(tbl[idx].ls));
                chk($sformatf("v%0d_fs", idx), 32'(fs0), 32'(tbl[idx].fs));
                idx++;
            end
            if (n < 100) begin
                if (pe0) pe_cnt0++;
                if (pe0 !== (n % 2 == 0)) alt_bad++;
            end
            if (n > 0 && x0 != prev_x && !prev_pe) xadv_bad++;
            prev_x = x0; prev_pe = pe0;
            if (n < 1600) begin
                if (!hs0) hs_low0++;
                if (ls0) ls_cnt0++;
            end
            if (n < 50 && pe1) pe_cnt1++;
            if (n < 120) begin
                if (hs1) hs_hi1++;
                if (vs1) vs_hi1++;
                if (fs1) fs_cnt1++;
            end
            if (n < 99 && pe2) pe_cnt2++;
            if (n == 0) chk("d2_pe_n0", 32'(pe2), 0);
            if (n == 1) chk("d2_first_pe_fs", 32'({pe2, fs2}), 32'h3);
            if (n == 2) chk("d2_x_n2", 32'(x2), 1);
            if (n == 119) chk("d1_last_pos", 32'({x1, y1}), 32'({10'd14, 10'd7}));
            if (n == 120) chk("d1_wrap_pos_fs", 32'({x1, y1, fs1}), 32'({10'd0, 10'd0, 1'b1}));
            if (n == 52) chk("d1_pos52", 32'({x1, y1, act1}), 32'({10'd7, 10'd3, 1'b1}));
        end
        chk("tbl_consumed", 32'(idx), NV);
        chk("d0_pe_per100", 32'(pe_cnt0), 50);
        chk("d0_pe_alternate", 32'(alt_bad), 0);
        chk("d0_x_adv_only_on_pe", 32'(xadv_bad), 0);
        chk("d0_hs_low_per_line", 32'(hs_low0), 192);
        chk("d0_ls_per_line", 32'(ls_cnt0), 1);
        chk("d1_pe_per50", 32'(pe_cnt1), 50);
        chk("d1_hs_hi_per_frame", 32'(hs_hi1), 24);
        chk("d1_vs_hi_per_frame", 32'(vs_hi1), 30);
        chk("d1_fs_per_frame", 32'(fs_cnt1), 1);
        chk("d2_pe_per99", 32'(pe_cnt2), 33);

        // Mid-frame reset pulse on the small instance at (7,3).
        waited = 0;
        while (!(x1 == 10'd7 && y1 == 10'd3) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("midrst_reach_pos", 32'(waited < 200), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst1_pos", 32'({x1, y1}), 0);
        chk("midrst1_syncs", 32'({hs1, vs1}), 0);
        chk("midrst1_pe_strobes", 32'({pe1, ls1, fs1}), 0);
        chk("midrst1_act", 32'(act1), 1);
        chk("midrst0_state", 32'({x0, y0, hs0, vs0, pe0}), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart1_pe_fs", 32'({pe1, fs1}), 32'h3);
        chk("restart0_pe_fs_x", 32'({pe0, fs0, x0}), 32'({1'b1, 1'b1, 10'd0}));
        chk("restart2_pe", 32'(pe2), 0);
        repeat (15) @(negedge clk);
        chk("restart1_line1", 32'({x1, y1, ls1, fs1}), 32'({10'd0, 10'd1, 1'b1, 1'b0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
